// File: rtl/fetch_pkg.sv
// Shared types and constants for the 4-bit CPU instruction fetch unit.
// FETCH_PREFETCH_EN selects a two-entry prefetch buffer; otherwise one entry.
package fetch_pkg;

  localparam int unsigned ADDR_W  = 5;
  localparam int unsigned DATA_W  = 4;
  localparam int unsigned INSTR_W = 2 * DATA_W;

`ifdef FETCH_PREFETCH_EN
  localparam int unsigned DEPTH = 2;
`else
  localparam int unsigned DEPTH = 1;
`endif

  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    StIssueOp,
    StCapOp,
    StCapArg,
    StStall
  } fetch_state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Memory read port, jump redirect and decoder handshake of the fetch unit.
interface fetch_unit_if;
  import fetch_pkg::*;

  logic               mem_we;
  logic [ADDR_W-1:0]  mem_addr;
  logic [DATA_W-1:0]  mem_rdata;
  logic               jump_valid;
  logic [ADDR_W-1:0]  jump_addr;
  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instr_data;
  logic [ADDR_W-1:0]  instr_pc;

  modport master (
    output mem_we, mem_addr, instr_valid, instr_data, instr_pc,
    input  mem_rdata, jump_valid, jump_addr, instr_ready
  );

  modport slave (
    input  mem_we, mem_addr, instr_valid, instr_data, instr_pc,
    output mem_rdata, jump_valid, jump_addr, instr_ready
  );

endinterface

// File: rtl/fetch_buffer.sv
// Small synchronous FIFO of fetched instructions; slot 0 is always the head.
// Flush beats push; a pop on an empty buffer is ignored.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int unsigned Depth = DEPTH,
  parameter int unsigned OccW  = $clog2(Depth + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push_i,
  input  fetch_entry_t    push_entry_i,
  input  logic            pop_i,
  input  logic            flush_i,
  output fetch_entry_t    head_o,
  output logic [OccW-1:0] occupancy_o
);

  fetch_entry_t [Depth-1:0] slots_q, slots_d;
  logic [OccW-1:0]          count_q, count_d;
  logic [OccW-1:0]          wr_idx;
  logic                     do_pop;

  assign do_pop = pop_i && (count_q != '0);
  // The slot to write shifts down by one when the head leaves this cycle.
  assign wr_idx = count_q - OccW'(do_pop);

  always_comb begin
    slots_d = slots_q;
    count_d = count_q;
    if (flush_i) begin
      count_d = '0;
    end else begin
      if (do_pop) begin
        for (int i = 0; i < int'(Depth) - 1; i++) begin
          slots_d[i] = slots_q[i+1];
        end
      end
      for (int i = 0; i < int'(Depth); i++) begin
        if (push_i && (wr_idx == OccW'(i))) begin
          slots_d[i] = push_entry_i;
        end
      end
      count_d = count_q + OccW'(push_i) - OccW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      slots_q <= '0;
      count_q <= '0;
    end else begin
      slots_q <= slots_d;
      count_q <= count_d;
    end
  end

  assign head_o      = slots_q[0];
  assign occupancy_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: reads opcode/operand nibble pairs into a prefetch
// buffer (two entries when FETCH_PREFETCH_EN is defined, else one).
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
);

  fetch_state_t       state_q;
  logic [ADDR_W-1:0]  pc_q;
  logic [ADDR_W-1:0]  mem_addr_q;
  logic [DATA_W-1:0]  opcode_q;

  fetch_entry_t       head;
  fetch_entry_t       new_entry;
  logic [OCC_W-1:0]   occ;
  logic [OCC_W-1:0]   occ_after;
  logic               push;
  logic               pop;
  logic               has_room;
  logic [ADDR_W-1:0]  pc_plus1;
  logic [ADDR_W-1:0]  pc_plus2;

  assign pc_plus1 = pc_q + ADDR_W'(1);
  assign pc_plus2 = pc_q + ADDR_W'(2);

  assign pop       = bus.instr_valid && bus.instr_ready;
  assign push      = (state_q == StCapArg) && !bus.jump_valid;
  assign occ_after = occ + OCC_W'(push) - OCC_W'(pop);
  assign has_room  = occ_after < OCC_W'(DEPTH);

  assign new_entry.instr = {opcode_q, bus.mem_rdata};
  assign new_entry.pc    = pc_q;

  fetch_buffer #(
    .Depth (DEPTH),
    .OccW  (OCC_W)
  ) u_buffer (
    .clk_i        (clk),
    .rst_i        (rst),
    .push_i       (push),
    .push_entry_i (new_entry),
    .pop_i        (pop),
    .flush_i      (bus.jump_valid),
    .head_o       (head),
    .occupancy_o  (occ)
  );

  // mem_addr is registered: it is loaded with the address the next state reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIssueOp;
      pc_q       <= RESET_PC;
      mem_addr_q <= RESET_PC;
      opcode_q   <= '0;
    end else if (bus.jump_valid) begin
      state_q    <= StIssueOp;
      pc_q       <= bus.jump_addr;
      mem_addr_q <= bus.jump_addr;
      opcode_q   <= '0;
    end else begin
      unique case (state_q)
        StIssueOp: begin
          mem_addr_q <= pc_plus1;
          state_q    <= StCapOp;
        end
        StCapOp: begin
          opcode_q <= bus.mem_rdata;
          state_q  <= StCapArg;
        end
        StCapArg: begin
          pc_q <= pc_plus2;
          if (has_room) begin
            mem_addr_q <= pc_plus2;
            state_q    <= StIssueOp;
          end else begin
            state_q <= StStall;
          end
        end
        StStall: begin
          if (has_room) begin
            mem_addr_q <= pc_q;
            state_q    <= StIssueOp;
          end
        end
        default: state_q <= StIssueOp;
      endcase
    end
  end

  assign bus.mem_we      = 1'b0;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.instr_valid = (occ != '0);
  assign bus.instr_data  = head.instr;
  assign bus.instr_pc    = head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run
// against an instruction-stream reference model.
module tb_fetch_unit;
  import fetch_pkg::*;

  // Cycles between successive instructions with the decoder always ready.
  localparam int P = (DEPTH == 2) ? 3 : 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [DATA_W-1:0] mem [2**ADDR_W];

  fetch_unit_if bus ();

  fetch_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk) bus.mem_rdata <= mem[bus.mem_addr];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [INSTR_W-1:0] ref_instr(input logic [ADDR_W-1:0] pc);
    logic [ADDR_W-1:0] nxt;
    nxt = pc + 1'b1;
    return {mem[pc], mem[nxt]};
  endfunction

  task automatic load_counting();
    for (int i = 0; i < 6; i++) mem[i] = DATA_W'(i + 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.jump_valid  = 1'b0;
    bus.instr_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    load_counting();
    rst = 1'b1;
    step();
    step();
    checks++;
    if (bus.mem_we !== 1'b0) begin
      errors++; $display("FAIL reset_mem_we: got %b want 0", bus.mem_we);
    end
    checks++;
    if (bus.mem_addr !== ADDR_W'(0)) begin
      errors++; $display("FAIL reset_mem_addr: got %0d want 0", bus.mem_addr);
    end
    checks++;
    if (bus.instr_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b want 0", bus.instr_valid);
    end
    checks++;
    if (bus.instr_data !== '0 || bus.instr_pc !== '0) begin
      errors++;
      $display("FAIL reset_instr: got %h@%0d want 00@0", bus.instr_data, bus.instr_pc);
    end
  endtask

  task automatic test_sequential();
    int idx;
    logic [ADDR_W-1:0] epc;
    load_counting();
    do_reset();
    bus.instr_ready = 1'b1;
    for (int k = 1; k <= 3 + 2 * P; k++) begin
      logic ev;
      step();
      ev = (k == 3) || (k == 3 + P) || (k == 3 + 2 * P);
      checks++;
      if (bus.instr_valid !== ev) begin
        errors++; $display("FAIL seq_valid k=%0d: got %b want %b", k, bus.instr_valid, ev);
      end
      if (ev) begin
        idx = (k - 3) / P;
        epc = ADDR_W'(2 * idx);
        checks++;
        if (bus.instr_data !== ref_instr(epc) || bus.instr_pc !== epc) begin
          errors++;
          $display("FAIL seq_instr k=%0d: got %h@%0d want %h@%0d", k, bus.instr_data,
                   bus.instr_pc, ref_instr(epc), epc);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [ADDR_W-1:0] epc;
    load_counting();
    do_reset();
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k >= 3) begin
        checks++;
        if (bus.instr_valid !== 1'b1 || bus.instr_data !== 8'h12 || bus.instr_pc !== '0) begin
          errors++;
          $display("FAIL bp_head k=%0d: got v=%b %h@%0d want v=1 12@0", k, bus.instr_valid,
                   bus.instr_data, bus.instr_pc);
        end
      end
    end
    checks++;
    if (bus.mem_addr !== ADDR_W'(2 * DEPTH - 1)) begin
      errors++; $display("FAIL bp_stall_addr: got %0d want %0d", bus.mem_addr, 2 * DEPTH - 1);
    end
    bus.instr_ready = 1'b1;
    for (int k = 0; k <= 4; k++) begin
      logic ev;
      ev = (k == 0) || (k == 4) || (k == 1 && DEPTH == 2);
      checks++;
      if (bus.instr_valid !== ev) begin
        errors++; $display("FAIL bp_release_valid k=%0d: got %b want %b", k, bus.instr_valid, ev);
      end
      if (ev) begin
        epc = (k == 0) ? ADDR_W'(0) : (k == 1) ? ADDR_W'(2) : ADDR_W'(2 * DEPTH);
        checks++;
        if (bus.instr_data !== ref_instr(epc) || bus.instr_pc !== epc) begin
          errors++;
          $display("FAIL bp_release_instr k=%0d: got %h@%0d want %h@%0d", k, bus.instr_data,
                   bus.instr_pc, ref_instr(epc), epc);
        end
      end
      if (k < 4) step();
    end
  endtask

  task automatic test_jump_cap_op();
    load_counting();
    mem[10] = 4'hA;
    mem[11] = 4'h5;
    do_reset();
    bus.instr_ready = 1'b1;
    step();
    bus.jump_valid = 1'b1;
    bus.jump_addr  = ADDR_W'(10);
    for (int k = 1; k <= 4; k++) begin
      step();
      bus.jump_valid = 1'b0;
      checks++;
      if (bus.instr_valid !== (k == 4)) begin
        errors++; $display("FAIL jump_valid k=%0d: got %b want %b", k, bus.instr_valid, k == 4);
      end
    end
    checks++;
    if (bus.instr_data !== 8'hA5 || bus.instr_pc !== ADDR_W'(10)) begin
      errors++; $display("FAIL jump_target: got %h@%0d want a5@10", bus.instr_data, bus.instr_pc);
    end
  endtask

  task automatic test_wrap();
    mem[31] = 4'h7;
    mem[0]  = 4'h9;
    mem[1]  = 4'h3;
    mem[2]  = 4'hC;
    do_reset();
    bus.instr_ready = 1'b1;
    bus.jump_valid  = 1'b1;
    bus.jump_addr   = ADDR_W'(31);
    for (int k = 1; k <= 4 + P; k++) begin
      logic ev;
      step();
      bus.jump_valid = 1'b0;
      if (k == 2) begin
        checks++;
        if (bus.mem_addr !== '0) begin
          errors++; $display("FAIL wrap_addr: got %0d want 0", bus.mem_addr);
        end
      end
      ev = (k == 4) || (k == 4 + P);
      checks++;
      if (bus.instr_valid !== ev) begin
        errors++; $display("FAIL wrap_valid k=%0d: got %b want %b", k, bus.instr_valid, ev);
      end
    end
    checks++;
    if (bus.instr_data !== 8'h3C || bus.instr_pc !== ADDR_W'(1)) begin
      errors++; $display("FAIL wrap_next: got %h@%0d want 3c@1", bus.instr_data, bus.instr_pc);
    end
  endtask

  task automatic test_wrap_first();
    // Same scenario, checking the wrapped instruction itself.
    mem[31] = 4'h7;
    mem[0]  = 4'h9;
    do_reset();
    bus.instr_ready = 1'b0;
    bus.jump_valid  = 1'b1;
    bus.jump_addr   = ADDR_W'(31);
    for (int k = 1; k <= 4; k++) begin
      step();
      bus.jump_valid = 1'b0;
    end
    checks++;
    if (bus.instr_valid !== 1'b1 || bus.instr_data !== 8'h79 || bus.instr_pc !== ADDR_W'(31)) begin
      errors++;
      $display("FAIL wrap_first: got v=%b %h@%0d want v=1 79@31", bus.instr_valid,
               bus.instr_data, bus.instr_pc);
    end
  endtask

  task automatic test_jump_pop();
    int pops;
    load_counting();
    mem[20] = 4'hE;
    mem[21] = 4'h2;
    do_reset();
    for (int k = 1; k <= 10; k++) step();
    bus.instr_ready = 1'b1;
    bus.jump_valid  = 1'b1;
    bus.jump_addr   = ADDR_W'(20);
    checks++;
    if (bus.instr_valid !== 1'b1 || bus.instr_data !== 8'h12) begin
      errors++;
      $display("FAIL jp_popped: got v=%b %h want v=1 12", bus.instr_valid, bus.instr_data);
    end
    pops = (bus.instr_valid === 1'b1) ? 1 : 0;
    for (int k = 1; k <= 3 + P; k++) begin
      step();
      bus.jump_valid = 1'b0;
      if (bus.instr_valid === 1'b1) pops++;
      checks++;
      if (bus.instr_valid !== (k == 4)) begin
        errors++; $display("FAIL jp_valid k=%0d: got %b want %b", k, bus.instr_valid, k == 4);
      end
      if (k == 4) begin
        checks++;
        if (bus.instr_data !== 8'hE2 || bus.instr_pc !== ADDR_W'(20)) begin
          errors++;
          $display("FAIL jp_target: got %h@%0d want e2@20", bus.instr_data, bus.instr_pc);
        end
      end
    end
    checks++;
    if (pops != 2) begin
      errors++; $display("FAIL jp_pop_count: got %0d want 2", pops);
    end
  endtask

  task automatic test_reset_mid();
    load_counting();
    do_reset();
    bus.instr_ready = 1'b1;
    step();
    step();
    rst = 1'b1;
    step();
    checks++;
    if (bus.instr_valid !== 1'b0 || bus.instr_data !== '0 || bus.instr_pc !== '0 ||
        bus.mem_addr !== '0 || bus.mem_we !== 1'b0) begin
      errors++;
      $display("FAIL rmid_outputs: got v=%b %h@%0d addr=%0d we=%b want v=0 00@0 addr=0 we=0",
               bus.instr_valid, bus.instr_data, bus.instr_pc, bus.mem_addr, bus.mem_we);
    end
    rst = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      step();
      checks++;
      if (bus.mem_we !== 1'b0) begin
        errors++; $display("FAIL rmid_we k=%0d: got %b want 0", k, bus.mem_we);
      end
      checks++;
      if (bus.instr_valid !== (k == 3)) begin
        errors++; $display("FAIL rmid_valid k=%0d: got %b want %b", k, bus.instr_valid, k == 3);
      end
    end
    checks++;
    if (bus.instr_data !== 8'h12 || bus.instr_pc !== '0) begin
      errors++; $display("FAIL rmid_refetch: got %h@%0d want 12@0", bus.instr_data, bus.instr_pc);
    end
  endtask

  task automatic test_random();
    logic [ADDR_W-1:0]  exp_pc;
    logic               after_jump;
    logic               hold;
    logic [INSTR_W-1:0] hold_data;
    logic [ADDR_W-1:0]  hold_pc;
    logic               rdy;
    logic               jmp;
    logic [ADDR_W-1:0]  jaddr;
    int                 pops;
    for (int i = 0; i < 2**ADDR_W; i++) mem[i] = DATA_W'($urandom);
    do_reset();
    exp_pc     = '0;
    after_jump = 1'b0;
    hold       = 1'b0;
    hold_data  = '0;
    hold_pc    = '0;
    pops       = 0;
    for (int c = 0; c < 800; c++) begin
      if (after_jump) begin
        checks++;
        if (bus.instr_valid !== 1'b0) begin
          errors++; $display("FAIL rnd_flush c=%0d: got valid %b want 0", c, bus.instr_valid);
        end
      end
      if (hold) begin
        checks++;
        if (bus.instr_valid !== 1'b1 || bus.instr_data !== hold_data || bus.instr_pc !== hold_pc)
        begin
          errors++;
          $display("FAIL rnd_stable c=%0d: got v=%b %h@%0d want v=1 %h@%0d", c, bus.instr_valid,
                   bus.instr_data, bus.instr_pc, hold_data, hold_pc);
        end
      end
      rdy   = ($urandom_range(0, 3) != 0);
      jmp   = ($urandom_range(0, 19) == 0);
      jaddr = ADDR_W'($urandom);
      if (bus.instr_valid === 1'b1 && rdy) begin
        checks++;
        if (bus.instr_data !== ref_instr(exp_pc) || bus.instr_pc !== exp_pc) begin
          errors++;
          $display("FAIL rnd_instr c=%0d: got %h@%0d want %h@%0d", c, bus.instr_data,
                   bus.instr_pc, ref_instr(exp_pc), exp_pc);
        end
        exp_pc = exp_pc + ADDR_W'(2);
        pops++;
      end
      if (jmp) exp_pc = jaddr;
      hold       = (bus.instr_valid === 1'b1) && !rdy && !jmp;
      hold_data  = bus.instr_data;
      hold_pc    = bus.instr_pc;
      after_jump = jmp;
      bus.instr_ready = rdy;
      bus.jump_valid  = jmp;
      bus.jump_addr   = jaddr;
      step();
    end
    bus.jump_valid = 1'b0;
    checks++;
    if (pops <= 20) begin
      errors++; $display("FAIL rnd_progress: got %0d pops want more than 20", pops);
    end
  endtask

  initial begin
    bus.jump_valid  = 1'b0;
    bus.jump_addr   = '0;
    bus.instr_ready = 1'b0;
    for (int i = 0; i < 2**ADDR_W; i++) mem[i] = '0;
    test_reset();
    test_sequential();
    test_backpressure();
    test_jump_cap_op();
    test_wrap();
    test_wrap_first();
    test_jump_pop();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
